// File: rtl/fp16_mac_pkg.sv
// Shared FP16 exponent constants and the default payload carried by the
// exponent-difference pipeline slices.
package fp16_mac_pkg;

    localparam int FP16_EXP_W     = 5;
    localparam int FP16_MAN_W     = 10;
    localparam int FP16_ALIGN_MAX = FP16_MAN_W + 1;

    typedef struct packed {
        logic [FP16_EXP_W-1:0] diff;
        logic                  a_lt_b;
        logic                  equal;
        logic [FP16_EXP_W-1:0] shift;
        logic                  sat;
    } exp_diff_t;

endpackage

// File: rtl/exp_diff_pipe_if.sv
// Operand/result handshake bundle of the exponent-difference pipeline.
interface exp_diff_pipe_if
    import fp16_mac_pkg::*;
#(
    parameter int WIDTH = FP16_EXP_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             a_lt_b;
    logic             equal;
    logic [WIDTH-1:0] shift;
    logic             sat;
    logic [15:0]      txn_count;
    logic [15:0]      sat_count;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, a_lt_b, equal, shift, sat,
               txn_count, sat_count
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, a_lt_b, equal, shift, sat,
               txn_count, sat_count
    );
endinterface

// File: rtl/exp_diff_stage.sv
// One valid/ready register slice; bubbles collapse because an empty slice
// always accepts, and a full one accepts whenever its entry moves on.
module exp_diff_stage
    import fp16_mac_pkg::*;
#(
    parameter type payload_t = exp_diff_t
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  payload_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output payload_t out_data
);
    logic     valid_r;
    payload_t data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice register: data only overwritten by a real entry so idle outputs keep their last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end
endmodule

// File: rtl/exp_diff_pipe.sv
// Biased-exponent difference with clamped alignment shift, STAGES register slices deep.
// Optional delivery statistics are enabled with macro EXP_DIFF_PIPE_STATS_EN.
module exp_diff_pipe
    import fp16_mac_pkg::*;
#(
    parameter int WIDTH     = FP16_EXP_W,
    parameter int STAGES    = 2,
    parameter int SHIFT_MAX = FP16_ALIGN_MAX
) (
    input  logic           clk,
    input  logic           rst_n,
    exp_diff_pipe_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             a_lt_b;
        logic             equal;
        logic [WIDTH-1:0] shift;
        logic             sat;
    } slice_t;

    localparam logic [WIDTH-1:0] SHIFT_CEIL = WIDTH'(SHIFT_MAX);

    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] mag_s;
    slice_t           res_s;

    // Borrow of the zero-extended subtraction selects which operand order gives |a-b|
    always_comb begin
        sub_s = {1'b0, bus.a} - {1'b0, bus.b};
        mag_s = '0;
        res_s = '0;
        if (sub_s[WIDTH]) begin
            mag_s = bus.b - bus.a;
        end else begin
            mag_s = sub_s[WIDTH-1:0];
        end
        res_s.diff   = mag_s;
        res_s.a_lt_b = sub_s[WIDTH];
        res_s.equal  = (bus.a == bus.b);
        if (mag_s > SHIFT_CEIL) begin
            res_s.sat   = 1'b1;
            res_s.shift = SHIFT_CEIL;
        end else begin
            res_s.sat   = 1'b0;
            res_s.shift = mag_s;
        end
    end

    logic [STAGES:0] valid_s;
    logic [STAGES:0] ready_s;
    slice_t          data_s [0:STAGES];

    assign valid_s[0]      = bus.in_valid;
    assign data_s[0]       = res_s;
    assign ready_s[STAGES] = bus.out_ready;
    assign bus.in_ready    = ready_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        exp_diff_stage #(
            .payload_t (slice_t)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (valid_s[k]),
            .in_ready  (ready_s[k]),
            .in_data   (data_s[k]),
            .out_valid (valid_s[k+1]),
            .out_ready (ready_s[k+1]),
            .out_data  (data_s[k+1])
        );
    end

    assign bus.out_valid = valid_s[STAGES];
    assign bus.diff      = data_s[STAGES].diff;
    assign bus.a_lt_b    = data_s[STAGES].a_lt_b;
    assign bus.equal     = data_s[STAGES].equal;
    assign bus.shift     = data_s[STAGES].shift;
    assign bus.sat       = data_s[STAGES].sat;

`ifdef EXP_DIFF_PIPE_STATS_EN
    logic [15:0] txn_r;
    logic [15:0] sat_r;

    // Delivery counters, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_r <= 16'h0000;
            sat_r <= 16'h0000;
        end else if (bus.out_valid && bus.out_ready) begin
            txn_r <= txn_r + 16'd1;
            if (bus.sat) begin
                sat_r <= sat_r + 16'd1;
            end
        end
    end

    assign bus.txn_count = txn_r;
    assign bus.sat_count = sat_r;
`else
    assign bus.txn_count = 16'h0000;
    assign bus.sat_count = 16'h0000;
`endif
endmodule

// File: tb/tb_exp_diff_pipe.sv
// Self-checking bench for exp_diff_pipe: directed table, random streaming,
// backpressure, mid-flight reset and statistics counters.
module tb_exp_diff_pipe;
    import fp16_mac_pkg::*;

    localparam int WIDTH     = 5;
    localparam int STAGES    = 2;
    localparam int SHIFT_MAX = 11;
    localparam int AMAX      = (1 << WIDTH) - 1;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             a_lt_b;
        logic             equal;
        logic [WIDTH-1:0] shift;
        logic             sat;
    } res_t;

    typedef struct {
        int   a;
        int   b;
        res_t res;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    exp_diff_pipe_if #(.WIDTH(WIDTH)) bus ();

    exp_diff_pipe #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .SHIFT_MAX (SHIFT_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic res_t model(input int a, input int b);
        res_t r;
        int   d;
        d        = a - b;
        r.a_lt_b = (d < 0);
        if (d < 0) d = -d;
        r.diff   = WIDTH'(d);
        r.equal  = (a == b);
        r.sat    = (d > SHIFT_MAX);
        r.shift  = WIDTH'((d > SHIFT_MAX) ? SHIFT_MAX : d);
        return r;
    endfunction

    function automatic vec_t mk(input int a, input int b, input int diff, input int lt,
                                input int eq, input int sh, input int st);
        vec_t v;
        v.a          = a;
        v.b          = b;
        v.res.diff   = WIDTH'(diff);
        v.res.a_lt_b = (lt != 0);
        v.res.equal  = (eq != 0);
        v.res.shift  = WIDTH'(sh);
        v.res.sat    = (st != 0);
        return v;
    endfunction

    res_t cur_s;
    assign cur_s = {bus.diff, bus.a_lt_b, bus.equal, bus.shift, bus.sat};

    res_t exp_q [$];
    res_t exp_v;
    res_t hold_v;
    logic hold_f  = 1'b0;
    int   exp_txn = 0;
    int   exp_sat = 0;

    // Scoreboard: sampled on the falling edge, between driver updates
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_txn = 0;
                exp_sat = 0;
                hold_f  = 1'b0;
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                if (hold_f) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_fields", 32'(cur_s), 32'(hold_v));
                end
`ifdef EXP_DIFF_PIPE_STATS_EN
                chk("txn_count", 32'(bus.txn_count), 32'(exp_txn[15:0]));
                chk("sat_count", 32'(bus.sat_count), 32'(exp_sat[15:0]));
`else
                chk("txn_count_off", 32'(bus.txn_count), 32'd0);
                chk("sat_count_off", 32'(bus.sat_count), 32'd0);
`endif
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 32'(cur_s), 32'hFFFF_FFFF);
                    end else begin
                        exp_v = exp_q.pop_front();
                        chk("result", 32'(cur_s), 32'(exp_v));
                        exp_txn++;
                        if (exp_v.sat) exp_sat++;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(int'(bus.a), int'(bus.b)));
                end
                hold_f = bus.out_valid && !bus.out_ready;
                hold_v = cur_s;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        bus.a = WIDTH'($urandom_range(0, AMAX));
        bus.b = WIDTH'($urandom_range(0, AMAX));
    endtask

    vec_t tbl [8];
    int   acc;

    initial begin
        tbl[0] = mk(20, 15,  5, 0, 0,  5, 0);
        tbl[1] = mk( 0, 31, 31, 1, 0, 11, 1);
        tbl[2] = mk( 9,  9,  0, 0, 1,  0, 0);
        tbl[3] = mk(31,  0, 31, 0, 0, 11, 1);
        tbl[4] = mk(12,  1, 11, 0, 0, 11, 0);
        tbl[5] = mk(13,  1, 12, 0, 0, 11, 1);
        tbl[6] = mk( 0,  0,  0, 0, 1,  0, 0);
        tbl[7] = mk( 3,  7,  4, 1, 0,  4, 0);

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_fields", 32'(cur_s), 32'd0);
        chk("reset_txn", 32'(bus.txn_count), 32'd0);
        chk("reset_sat", 32'(bus.sat_count), 32'd0);
        rst_n = 1'b1;
        step();
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Directed table with exact latency
        for (int i = 0; i < 8; i++) begin
            bus.a        = WIDTH'(tbl[i].a);
            bus.b        = WIDTH'(tbl[i].b);
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("lat_early_%0d", i), 32'(bus.out_valid), 32'(STAGES == 1));
            repeat (STAGES - 1) step();
            chk($sformatf("lat_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec_%0d", i), 32'(cur_s), 32'(tbl[i].res));
            step();
        end

        // Back-to-back random stream
        for (int i = 0; i < 100; i++) begin
            drive_rand();
            bus.in_valid = 1'b1;
            chk("rand_in_ready", 32'(bus.in_ready), 32'd1);
            step();
            if (i + 1 >= STAGES) chk("rand_throughput", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        repeat (STAGES + 1) step();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: pipeline fills, then stalls
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive_rand();
            bus.in_valid = 1'b1;
            #1;
            if (bus.in_ready) acc++;
            step();
        end
        chk("bp_accepts", 32'(acc), 32'(STAGES));
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        drive_rand();
        #1;
        chk("full_pass_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("full_occupancy", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        repeat (STAGES + 1) step();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_idle", 32'(bus.out_valid), 32'd0);

        // Reset with results in flight
        for (int i = 0; i < 2; i++) begin
            drive_rand();
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_flight_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_flight_fields", 32'(cur_s), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_stale", 32'(bus.out_valid), 32'd0);
        end

`ifdef EXP_DIFF_PIPE_STATS_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.a        = '0;
        bus.b        = '0;
        bus.in_valid = 1'b1;
        repeat (65537) step();
        bus.in_valid = 1'b0;
        repeat (STAGES + 1) step();
        chk("txn_wrap", 32'(bus.txn_count), 32'd1);
        chk("sat_none", 32'(bus.sat_count), 32'd0);
        bus.a        = WIDTH'(0);
        bus.b        = WIDTH'(AMAX);
        bus.in_valid = 1'b1;
        repeat (3) step();
        bus.in_valid = 1'b0;
        repeat (STAGES + 1) step();
        chk("sat_three", 32'(bus.sat_count), 32'd3);
        chk("txn_after_sat", 32'(bus.txn_count), 32'd4);
`else
        bus.a        = WIDTH'(0);
        bus.b        = WIDTH'(AMAX);
        bus.in_valid = 1'b1;
        repeat (3) step();
        bus.in_valid = 1'b0;
        repeat (STAGES + 1) step();
        chk("txn_tied", 32'(bus.txn_count), 32'd0);
        chk("sat_tied", 32'(bus.sat_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
